// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU issue controller:
// ALUControl encodings, flag bit positions and the issue FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_ORR  = 4'b0011;
    localparam logic [3:0] ALU_MUL  = 4'b0100;
    localparam logic [3:0] ALU_MLA  = 4'b0101;
    localparam logic [3:0] ALU_EOR  = 4'b0110;
    localparam logic [3:0] ALU_MVN  = 4'b0111;
    localparam logic [3:0] ALU_QADD = 4'b1000;
    localparam logic [3:0] ALU_QSUB = 4'b1001;

    localparam int unsigned FLAG_N = 4;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Q = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULW = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } issue_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MLA);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips away from the winner
// whenever a grant is taken inside the enable window.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic rr_ptr;
    logic take;

    always_comb begin
        gnt_idx = 1'b0;
        if (req == 2'b10)
            gnt_idx = 1'b1;
        else if (req == 2'b11)
            gnt_idx = rr_ptr;
    end

    assign take = en && (req != 2'b00);
    assign gnt  = {take && gnt_idx, take && !gnt_idx};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= 1'b0;
        else if (take)
            rr_ptr <= ~gnt_idx;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares the execute ALU between the pipeline (port 0) and the coprocessor/debug
// port (port 1). Optional sticky-Q tracking is enabled by ALU_ISSUE_STICKY_Q_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [31:0]      req0_c,
    input  logic [3:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [31:0]      req1_c,
    input  logic [3:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [31:0]      alu_c,
    output logic [3:0]       alu_ctrl,
    input  logic [31:0]      alu_result,
    input  logic [4:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    input  logic             q_clr,
    output logic             q_sticky
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);

    issue_state_e     state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             window;
    logic             accept;
    logic [1:0]       gnt;
    logic             gnt_idx;
    logic [3:0]       sel_op;
    logic             sel_mul;
    logic             lat_id;
    logic [TAG_W-1:0] lat_tag;

    // RESP with rsp_ready retires the response and can issue in the same cycle.
    assign window = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({req1_valid, req0_valid}),
        .en      (window),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign accept     = |gnt;
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign sel_op     = gnt_idx ? req1_op : req0_op;
    assign sel_mul    = is_mul_op(sel_op) && (MUL_LAT != 0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (sel_mul) begin
                        state_nxt = ST_MULW;
                        cnt_nxt   = MUL_CNT;
                    end else begin
                        state_nxt = ST_EXEC;
                    end
                end else if ((state == ST_RESP) && rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_MULW: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1)
                    state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_RESP;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_c    <= '0;
            alu_ctrl <= '0;
            lat_id   <= 1'b0;
            lat_tag  <= '0;
        end else if (accept) begin
            alu_a    <= gnt_idx ? req1_a   : req0_a;
            alu_b    <= gnt_idx ? req1_b   : req0_b;
            alu_c    <= gnt_idx ? req1_c   : req0_c;
            alu_ctrl <= sel_op;
            lat_id   <= gnt_idx;
            lat_tag  <= gnt_idx ? req1_tag : req0_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_id     <= 1'b0;
            rsp_tag    <= '0;
        end else if (state == ST_EXEC) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_id     <= lat_id;
            rsp_tag    <= lat_tag;
        end
    end

    assign rsp_valid = (state == ST_RESP);

`ifdef ALU_ISSUE_STICKY_Q_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q_sticky <= 1'b0;
        else if ((state == ST_EXEC) && alu_flags[FLAG_Q])
            q_sticky <= 1'b1;
        else if (q_clr)
            q_sticky <= 1'b0;
    end
`else
    logic unused_q_clr;
    assign unused_q_clr = q_clr;
    assign q_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus random
// traffic against a transaction-level reference model with a behavioural ALU.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int unsigned TAG_W = 4;
    localparam int unsigned LAT   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0]      req0_a, req0_b, req0_c, req1_a, req1_b, req1_c;
    logic [3:0]       req0_op, req1_op;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic [31:0]      alu_a, alu_b, alu_c, alu_result;
    logic [3:0]       alu_ctrl;
    logic [4:0]       alu_flags;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [31:0]      rsp_result;
    logic [4:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic             q_clr, q_sticky;

    alu_issue_ctrl #(.TAG_W(TAG_W), .MUL_LAT(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_c(req0_c), .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_c(req1_c), .req1_op(req1_op), .req1_tag(req1_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .q_clr(q_clr), .q_sticky(q_sticky)
    );

    // Behavioural ALU: returns {N,Z,C,V,Q, result}.
    function automatic logic [36:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
        logic [32:0] w;
        logic [31:0] r;
        logic cf, vf, qf;
        w = '0; r = '0; cf = 1'b0; vf = 1'b0; qf = 1'b0;
        case (op)
            ALU_ADD:  begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cf = w[32];
                            vf = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB:  begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; cf = w[32];
                            vf = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND:  r = a & b;
            ALU_ORR:  r = a | b;
            ALU_EOR:  r = a ^ b;
            ALU_MVN:  r = ~b;
            ALU_MUL:  r = a * b;
            ALU_MLA:  r = a * b + c;
            ALU_QADD: begin r = a + b;
                            if ((a[31] == b[31]) && (r[31] != a[31])) begin
                                r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; qf = 1'b1; end end
            ALU_QSUB: begin r = a - b;
                            if ((a[31] != b[31]) && (r[31] != a[31])) begin
                                r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; qf = 1'b1; end end
            default:  r = '0;
        endcase
        return {r[31], (r == 32'd0), cf, vf, qf, r};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_ctrl, alu_a, alu_b, alu_c);

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, visible from m_vis_cyc until retired.
    bit          m_busy, m_rr, m_id, m_sticky;
    int          m_cyc, m_vis_cyc, last_gid;
    logic [3:0]  m_op, m_tag;
    logic [31:0] m_a, m_b, m_c, m_res;
    logic [4:0]  m_flg;

    task automatic model_reset();
        m_busy = 0; m_rr = 0; m_id = 0; m_sticky = 0; m_vis_cyc = 0; last_gid = -1;
        m_op = '0; m_tag = '0; m_a = '0; m_b = '0; m_c = '0; m_res = '0; m_flg = '0;
    endtask

    // Called at a falling edge with inputs already driven; checks and advances one cycle.
    task automatic step();
        bit vis, win, gid, acc;
        logic [36:0] e;
        #1;
        vis = m_busy && (m_cyc >= m_vis_cyc);
        win = !m_busy || (vis && rsp_ready);
        gid = (req0_valid && req1_valid) ? m_rr : req1_valid;
        acc = win && (req0_valid || req1_valid);
        check_val("req0_ready", req0_ready, acc && !gid);
        check_val("req1_ready", req1_ready, acc && gid);
        check_val("alu_ctrl", alu_ctrl, m_op);
        check_val("alu_a", alu_a, m_a);
        check_val("alu_b", alu_b, m_b);
        check_val("alu_c", alu_c, m_c);
        check_val("rsp_valid", rsp_valid, vis);
        if (vis) begin
            check_val("rsp_result", rsp_result, m_res);
            check_val("rsp_flags", rsp_flags, m_flg);
            check_val("rsp_id", rsp_id, m_id);
            check_val("rsp_tag", rsp_tag, m_tag);
        end
`ifdef ALU_ISSUE_STICKY_Q_EN
        check_val("q_sticky", q_sticky, m_sticky);
        if (m_busy && (m_cyc + 1 == m_vis_cyc) && m_flg[0])
            m_sticky = 1;
        else if (q_clr)
            m_sticky = 0;
`else
        check_val("q_sticky", q_sticky, 0);
`endif
        last_gid = -1;
        if (acc) begin
            if (gid) begin m_op = req1_op; m_a = req1_a; m_b = req1_b; m_c = req1_c; m_tag = req1_tag; end
            else     begin m_op = req0_op; m_a = req0_a; m_b = req0_b; m_c = req0_c; m_tag = req0_tag; end
            e = alu_model(m_op, m_a, m_b, m_c);
            m_res = e[31:0];
            m_flg = e[36:32];
            m_busy = 1;
            m_id = gid;
            m_vis_cyc = m_cyc + 2 + (((m_op == 4'd4) || (m_op == 4'd5)) ? LAT : 0);
            m_rr = !gid;
            last_gid = gid ? 1 : 0;
        end else if (vis && rsp_ready) begin
            m_busy = 0;
        end
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic set_req0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [3:0] tag);
        req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_c = c; req0_tag = tag;
    endtask

    task automatic set_req1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [3:0] tag);
        req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_c = c; req1_tag = tag;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; q_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    int gq[$];
    int exp_g[4];

    initial begin
        reset = 1'b0; rsp_ready = 1'b0; q_clr = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        set_req0(ALU_ADD, '0, '0, '0, '0); set_req1(ALU_ADD, '0, '0, '0, '0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        m_cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_result", rsp_result, 0);
        check_val("rst_alu_ctrl", alu_ctrl, 0);
        check_val("rst_q_sticky", q_sticky, 0);
        @(negedge clk);
        reset = 1'b1;

        // Reset while a MUL waits with cnt==1: no response, port 0 accepted right after.
        set_req0(ALU_MUL, 32'd7, 32'd6, 32'd0, 4'd1);
        step();
        req0_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check_val("t1_rsp_valid", rsp_valid, 0);
        check_val("t1_alu_ctrl", alu_ctrl, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // ADD 5+3 from port 0, response two cycles after accept.
        set_req0(ALU_ADD, 32'd5, 32'd3, 32'd0, 4'd2);
        rsp_ready = 1'b1;
        #1 check_val("t1_req0_ready", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        step();
        #1;
        check_val("t2_valid", rsp_valid, 1);
        check_val("t2_result", rsp_result, 32'd8);
        check_val("t2_flags", rsp_flags, 5'b00000);
        check_val("t2_id", rsp_id, 0);
        step();

        // Both ports busy from reset: grants alternate starting with port 0.
        do_reset();
        rsp_ready = 1'b1;
        set_req0(ALU_SUB, $urandom, $urandom, 32'd0, 4'd0);
        set_req1(ALU_SUB, $urandom, $urandom, 32'd0, 4'd8);
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_gid == 0) begin req0_tag = req0_tag + 4'd1; req0_a = $urandom; end
            if (last_gid == 1) begin req1_tag = req1_tag + 4'd1; req1_b = $urandom; end
            if (last_gid >= 0) gq.push_back(last_gid);
        end
        exp_g = '{0, 1, 0, 1};
        check_val("t3_grant_count", (gq.size() >= 4), 1);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            check_val("t3_grant_order", gq[i], exp_g[i]);

        // MLA 3*4+5 from port 1 with the multi-cycle wait.
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) step();
        set_req1(ALU_MLA, 32'd3, 32'd4, 32'd5, 4'd3);
        step();
        req1_valid = 1'b0;
        step();
        step();
        #1 check_val("t4_early", rsp_valid, 0);
        step();
        #1;
        check_val("t4_valid", rsp_valid, 1);
        check_val("t4_result", rsp_result, 32'd17);
        check_val("t4_id", rsp_id, 1);

        // Backpressure: response held, no accepts; release retires and accepts together.
        rsp_ready = 1'b0;
        set_req0(ALU_ADD, 32'd10, 32'd20, 32'd0, 4'd4);
        set_req1(ALU_EOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 4'd9);
        repeat (5) step();
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        #1;
        check_val("t5_req0_ready", req0_ready, 1);
        check_val("t5_result_held", rsp_result, 32'd17);
        step();
        req0_valid = 1'b0;
        repeat (3) step();

`ifdef ALU_ISSUE_STICKY_Q_EN
        set_req0(ALU_QADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 4'd5);
        step();
        req0_valid = 1'b0;
        step();
        #1;
        check_val("t6_result", rsp_result, 32'h7FFF_FFFF);
        check_val("t6_qflag", rsp_flags[0], 1);
        check_val("t6_sticky_set", q_sticky, 1);
        step();
        set_req0(ALU_ADD, 32'd1, 32'd1, 32'd0, 4'd6);
        step();
        req0_valid = 1'b0;
        repeat (2) step();
        #1 check_val("t6_sticky_hold", q_sticky, 1);
        q_clr = 1'b1;
        step();
        q_clr = 1'b0;
        #1 check_val("t6_sticky_clr", q_sticky, 0);
        step();
`endif

        // Random traffic; pending requests are held until accepted or occasionally dropped.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            if (!req0_valid || last_gid == 0) begin
                req0_valid = ($urandom_range(0, 1) == 1);
                req0_op = 4'($urandom_range(0, 15)); req0_tag = 4'($urandom);
                req0_a = rand_operand(); req0_b = rand_operand(); req0_c = rand_operand();
            end else if ($urandom_range(0, 9) == 0) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid || last_gid == 1) begin
                req1_valid = ($urandom_range(0, 1) == 1);
                req1_op = 4'($urandom_range(0, 15)); req1_tag = 4'($urandom);
                req1_a = rand_operand(); req1_b = rand_operand(); req1_c = rand_operand();
            end else if ($urandom_range(0, 9) == 0) begin
                req1_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            q_clr = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
